// File: rtl/ppi_bus_control.sv
// PPI bus control: captures a CPU read/write, inserts wait states, acks,
// then issues port/control strobes when the request is released.
`timescale 1ns/1ps
module ppi_bus_control #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int NUM_PORTS   = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_select,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic [NUM_PORTS-1:0]  write_port,
    output logic                  write_control,
    output logic [NUM_PORTS-1:0]  read_port,
    output logic [NUM_PORTS-1:0]  read_done,
    output logic                  ack,
    output logic                  bus_error
);
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = '1;
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_ok_q, rd_ok_d;
    logic                  wr_ok_q, wr_ok_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0]  wp_q, wp_d;
    logic [NUM_PORTS-1:0]  rp_q, rp_d;
    logic [NUM_PORTS-1:0]  rdn_q, rdn_d;
    logic                  wc_q, wc_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic req, hold_exit, exit_now, cap_port, cap_ctrl;

    function automatic logic [NUM_PORTS-1:0] onehot(
        input logic [ADDR_WIDTH-1:0] a
    );
        onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            onehot[i] = (a == ADDR_WIDTH'(i));
    endfunction

    assign req       = chip_select & (read_enable | write_enable);
    assign hold_exit = ~chip_select | ~(read_enable | write_enable);
    assign cap_port  = address < ADDR_WIDTH'(NUM_PORTS);
    assign cap_ctrl  = address == CTRL_ADDR;
    assign exit_now  = (state_q == HOLD) & hold_exit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_ok_d = rd_ok_q;
        wr_ok_d = wr_ok_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = address;
                    rd_ok_d = read_enable & ~write_enable & cap_port;
                    wr_ok_d = write_enable & ~read_enable
                            & (cap_port | cap_ctrl);
                    if (write_enable & ~read_enable)
                        data_d = data_bus_in;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:  state_d = HOLD;
            HOLD: if (hold_exit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from next-state values.
        ack_d = (state_d == ACK);
        err_d = ack_d & ~(rd_ok_d | wr_ok_d);
        rp_d  = '0;
        if (state_d != IDLE && rd_ok_d)
            rp_d = onehot(addr_d);
        rdn_d = '0;
        wp_d  = '0;
        wc_d  = 1'b0;
        if (exit_now && rd_ok_q)
            rdn_d = onehot(addr_q);
        if (exit_now && wr_ok_q && addr_q != CTRL_ADDR)
            wp_d = onehot(addr_q);
        if (exit_now && wr_ok_q && addr_q == CTRL_ADDR)
            wc_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_ok_q <= 1'b0;
            wr_ok_q <= 1'b0;
            data_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            rdn_q   <= '0;
            wc_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_ok_q <= rd_ok_d;
            wr_ok_q <= wr_ok_d;
            data_q  <= data_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rdn_q   <= rdn_d;
            wc_q    <= wc_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign internal_data_bus = data_q;
    assign write_port        = wp_q;
    assign write_control     = wc_q;
    assign read_port         = rp_q;
    assign read_done         = rdn_q;
    assign ack               = ack_q;
    assign bus_error         = err_q;
endmodule

// File: tb/tb_ppi_bus_control.sv
// Bench for ppi_bus_control: three configurations on shared stimulus,
// checked against a transaction-timestamp model plus directed vectors.
`timescale 1ns/1ps
module tb_ppi_bus_control;
    typedef struct packed {
        logic        ack;
        logic        err;
        logic        wc;
        logic [7:0]  wp;
        logic [7:0]  rp;
        logic [7:0]  rdn;
        logic [15:0] idb;
    } obs_t;

    typedef struct {
        logic       cs, rd, wr;
        logic [2:0] a;
        logic [15:0] d;
        obs_t       e;
    } vec_t;

    localparam int WS_P [3] = '{0, 3, 3};
    localparam int AW_P [3] = '{2, 3, 2};
    localparam int NP_P [3] = '{3, 5, 3};
    localparam int DW_P [3] = '{8, 16, 8};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0]  addr = '0;
    logic [15:0] data = '0;

    logic [7:0]  a_idb;  logic [2:0] a_wp, a_rp, a_rdn;
    logic        a_wc, a_ack, a_err;
    logic [15:0] b_idb;  logic [4:0] b_wp, b_rp, b_rdn;
    logic        b_wc, b_ack, b_err;
    logic [7:0]  c_idb;  logic [2:0] c_wp, c_rp, c_rdn;
    logic        c_wc, c_ack, c_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ppi_bus_control u_a (
        .clock(clk), .reset_n(rst_n), .chip_select(cs),
        .read_enable(rd), .write_enable(wr),
        .address(addr[1:0]), .data_bus_in(data[7:0]),
        .internal_data_bus(a_idb), .write_port(a_wp),
        .write_control(a_wc), .read_port(a_rp),
        .read_done(a_rdn), .ack(a_ack), .bus_error(a_err)
    );

    ppi_bus_control #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3),
        .NUM_PORTS(5), .WAIT_STATES(3)
    ) u_b (
        .clock(clk), .reset_n(rst_n), .chip_select(cs),
        .read_enable(rd), .write_enable(wr),
        .address(addr), .data_bus_in(data),
        .internal_data_bus(b_idb), .write_port(b_wp),
        .write_control(b_wc), .read_port(b_rp),
        .read_done(b_rdn), .ack(b_ack), .bus_error(b_err)
    );

    ppi_bus_control #(.WAIT_STATES(3)) u_c (
        .clock(clk), .reset_n(rst_n), .chip_select(cs),
        .read_enable(rd), .write_enable(wr),
        .address(addr[1:0]), .data_bus_in(data[7:0]),
        .internal_data_bus(c_idb), .write_port(c_wp),
        .write_control(c_wc), .read_port(c_rp),
        .read_done(c_rdn), .ack(c_ack), .bus_error(c_err)
    );

    obs_t act [3];
    assign act[0] = {a_ack, a_err, a_wc, 8'(a_wp), 8'(a_rp),
                     8'(a_rdn), 16'(a_idb)};
    assign act[1] = {b_ack, b_err, b_wc, 8'(b_wp), 8'(b_rp),
                     8'(b_rdn), b_idb};
    assign act[2] = {c_ack, c_err, c_wc, 8'(c_wp), 8'(c_rp),
                     8'(c_rdn), 16'(c_idb)};

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     nm, got, want, $time);
        end
    endtask

    // Model: each operation is a capture timestamp; ack lands WS cycles
    // later, exit is the first idle-request edge from cap+WS+2 onward.
    int          cyc = 0;
    bit          busy [3];
    int          cap  [3];
    bit          o_rd [3];
    bit          o_wr [3];
    int          o_a  [3];
    logic [15:0] idb_m [3];
    obs_t        exp_o [3];

    function automatic void model_step(int d);
        int a, ctl;
        bit ex, vr, vw;
        obs_t e;
        ctl = (1 << AW_P[d]) - 1;
        a   = int'(addr) & ctl;
        ex  = 1'b0;
        if (!busy[d]) begin
            if (cs && (rd || wr)) begin
                busy[d] = 1'b1;
                cap[d]  = cyc;
                o_rd[d] = rd;
                o_wr[d] = wr;
                o_a[d]  = a;
                if (wr && !rd)
                    idb_m[d] = 16'(int'(data) & ((1 << DW_P[d]) - 1));
            end
        end else if (cyc >= cap[d] + WS_P[d] + 2 &&
                     (!cs || (!rd && !wr))) begin
            busy[d] = 1'b0;
            ex      = 1'b1;
        end
        vr = o_rd[d] && !o_wr[d] && o_a[d] < NP_P[d];
        vw = o_wr[d] && !o_rd[d] && (o_a[d] < NP_P[d] || o_a[d] == ctl);
        e = '0;
        e.idb = idb_m[d];
        if (busy[d] && cyc == cap[d] + WS_P[d]) begin
            e.ack = 1'b1;
            e.err = !(vr || vw);
        end
        if (busy[d] && vr) e.rp = 8'(1 << o_a[d]);
        if (ex && vr) e.rdn = 8'(1 << o_a[d]);
        if (ex && vw && o_a[d] < NP_P[d]) e.wp = 8'(1 << o_a[d]);
        if (ex && vw && o_a[d] == ctl) e.wc = 1'b1;
        exp_o[d] = e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                busy[d]  = 1'b0;
                idb_m[d] = '0;
                exp_o[d] = '0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 3; d++) model_step(d);
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            for (int d = 0; d < 3; d++)
                check($sformatf("model_dut%0d", d), 64'(act[d]),
                      64'(exp_o[d]));
    end

    function automatic vec_t mk(bit c, bit r, bit w, int a, int dd,
                                bit k, bit er, int wp, bit wc,
                                int rp, int rdn, int idb);
        vec_t v;
        v.cs = c; v.rd = r; v.wr = w;
        v.a = 3'(a); v.d = 16'(dd);
        v.e = '{ack: k, err: er, wc: wc, wp: 8'(wp), rp: 8'(rp),
                rdn: 8'(rdn), idb: 16'(idb)};
        return v;
    endfunction

    task automatic idle(int n);
        @(negedge clk);
        cs = 0; rd = 0; wr = 0;
        repeat (n) @(negedge clk);
    endtask

    vec_t tbl [26];
    int   hold_n;
    int   r;

    initial begin
        // Default-config vectors (dut 0, no wait states)
        tbl[0]  = mk(1,0,1,1,'hA5, 1,0,0,0,0,0,'hA5);
        tbl[1]  = mk(1,0,1,1,'hA5, 0,0,0,0,0,0,'hA5);
        tbl[2]  = mk(1,0,1,1,'hA5, 0,0,0,0,0,0,'hA5);
        tbl[3]  = mk(1,0,1,1,'hA5, 0,0,0,0,0,0,'hA5);
        tbl[4]  = mk(1,0,0,1,'hA5, 0,0,2,0,0,0,'hA5);
        tbl[5]  = mk(0,0,0,0,0,    0,0,0,0,0,0,'hA5);
        tbl[6]  = mk(1,0,1,3,'h80, 1,0,0,0,0,0,'h80);
        tbl[7]  = mk(1,0,0,3,0,    0,0,0,0,0,0,'h80);
        tbl[8]  = mk(0,0,0,0,0,    0,0,0,1,0,0,'h80);
        tbl[9]  = mk(1,1,0,3,0,    1,1,0,0,0,0,'h80);
        tbl[10] = mk(1,1,0,3,0,    0,0,0,0,0,0,'h80);
        tbl[11] = mk(0,0,0,0,0,    0,0,0,0,0,0,'h80);
        tbl[12] = mk(1,1,1,1,'h5A, 1,1,0,0,0,0,'h80);
        tbl[13] = mk(0,0,0,0,0,    0,0,0,0,0,0,'h80);
        tbl[14] = mk(0,0,0,0,0,    0,0,0,0,0,0,'h80);
        tbl[15] = mk(1,1,0,0,0,    1,0,0,0,1,0,'h80);
        tbl[16] = mk(1,1,0,1,0,    0,0,0,0,1,0,'h80);
        tbl[17] = mk(0,0,0,0,0,    0,0,0,0,0,1,'h80);
        tbl[18] = mk(0,0,0,0,0,    0,0,0,0,0,0,'h80);
        tbl[19] = mk(1,0,1,2,'hC3, 1,0,0,0,0,0,'hC3);
        tbl[20] = mk(1,0,1,2,'hFF, 0,0,0,0,0,0,'hC3);
        tbl[21] = mk(1,0,0,2,'hFF, 0,0,4,0,0,0,'hC3);
        tbl[22] = mk(1,0,1,2,'h3C, 1,0,0,0,0,0,'h3C);
        tbl[23] = mk(1,0,1,2,'h3C, 0,0,0,0,0,0,'h3C);
        tbl[24] = mk(0,0,0,0,0,    0,0,4,0,0,0,'h3C);
        tbl[25] = mk(0,0,0,0,0,    0,0,0,0,0,0,'h3C);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_dut%0d", d), 64'(act[d]), 64'(0));

        // Release and present row 0 in the same step: first edge captures.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            cs = tbl[i].cs; rd = tbl[i].rd; wr = tbl[i].wr;
            addr = tbl[i].a; data = tbl[i].d;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 64'(act[0]), 64'(tbl[i].e));
        end

        // Wait-state read on the 3-port, 3-wait config (dut 2)
        idle(8);
        cs = 1; rd = 1; wr = 0; addr = 2;
        @(posedge clk); #1;
        check("rd_ws_rp_cap", 64'(act[2].rp), 64'h4);
        check("rd_ws_noack0", 64'(act[2].ack), 64'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rd_ws_noack", 64'(act[2].ack), 64'h0);
            check("rd_ws_rp", 64'(act[2].rp), 64'h4);
        end
        @(posedge clk); #1;
        check("rd_ws_ack", 64'({act[2].ack, act[2].err}), 64'h2);
        @(posedge clk); #1;
        check("rd_ws_hold", 64'({act[2].ack, act[2].rp}), 64'h4);
        @(negedge clk);
        cs = 0; rd = 0;
        @(posedge clk); #1;
        check("rd_ws_exit", 64'({act[2].rp, act[2].rdn}), 64'h0004);
        @(posedge clk); #1;
        check("rd_ws_done", 64'(act[2].rdn), 64'h0);

        // Reset in the middle of a waited write
        idle(8);
        cs = 1; rd = 0; wr = 1; addr = 1; data = 'h77;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("rst_mid_dut%0d", d), 64'(act[d]), 64'(0));
        @(negedge clk);
        cs = 0; wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("rst_quiet", 64'({act[2].ack, act[2].wc, act[2].wp}),
                  64'h0);
        end

        // Wide config (dut 1): port 4 write, then unmapped address 5
        idle(8);
        cs = 1; rd = 0; wr = 1; addr = 4; data = 'h1234;
        @(posedge clk); #1;
        check("wide_idb", 64'(act[1].idb), 64'h1234);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("wide_ack", 64'({act[1].ack, act[1].err}), 64'h2);
        @(negedge clk);
        wr = 0;
        @(posedge clk); #1;
        check("wide_nowp", 64'(act[1].wp), 64'h0);
        @(posedge clk); #1;
        check("wide_wp", 64'({act[1].wp, act[1].idb}), 64'h10_1234);
        @(posedge clk); #1;
        check("wide_wp_off", 64'(act[1].wp), 64'h0);
        @(negedge clk);
        wr = 1; addr = 5;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        check("wide_err", 64'({act[1].ack, act[1].err}), 64'h3);
        @(negedge clk);
        wr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("wide_nostrobe",
              64'({act[1].wc, act[1].wp, act[1].rp, act[1].rdn}), 64'h0);
        check("wide_idb_keep", 64'(act[1].idb), 64'h1234);

        // Randomized traffic with occasional asynchronous resets
        idle(8);
        hold_n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if (hold_n == 0) begin
                cs   = ($urandom_range(0, 4) != 0);
                r    = int'($urandom_range(0, 9));
                rd   = (r < 4) || (r == 9);
                wr   = (r >= 4 && r < 8) || (r == 9);
                addr = 3'($urandom);
                data = 16'($urandom);
                hold_n = int'($urandom_range(0, 5));
            end else begin
                hold_n--;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
